// File: rtl/biu_seg_sequencer_if.sv
// Bundle of requester handshakes, segment-file port and physical-address channel
// around the BIU segment sequencer.
interface biu_seg_sequencer_if;
  logic        pf_req;
  logic [15:0] pf_off;
  logic        pf_ack;
  logic        eu_req;
  logic [1:0]  eu_seg;
  logic [15:0] eu_off;
  logic        eu_ack;
  logic        sw_req;
  logic [1:0]  sw_sel;
  logic [15:0] sw_data;
  logic        sw_ack;
  logic [1:0]  seg_wr_addr;
  logic        seg_wr_en;
  logic [15:0] seg_wr_data;
  logic [1:0]  seg_rd_addr;
  logic        seg_rd_en;
  logic [15:0] seg_rd_data;
  logic        pa_valid;
  logic [19:0] pa;
  logic        pa_src;
  logic        pa_ready;

  // Sequencer side.
  modport master (
    input  pf_req, pf_off, eu_req, eu_seg, eu_off, sw_req, sw_sel, sw_data,
    input  seg_rd_data, pa_ready,
    output pf_ack, eu_ack, sw_ack,
    output seg_wr_addr, seg_wr_en, seg_wr_data, seg_rd_addr, seg_rd_en,
    output pa_valid, pa, pa_src
  );

  // Requesters, segment file and bus cycle unit.
  modport slave (
    output pf_req, pf_off, eu_req, eu_seg, eu_off, sw_req, sw_sel, sw_data,
    output seg_rd_data, pa_ready,
    input  pf_ack, eu_ack, sw_ack,
    input  seg_wr_addr, seg_wr_en, seg_wr_data, seg_rd_addr, seg_rd_en,
    input  pa_valid, pa, pa_src
  );
endinterface

// File: rtl/biu_seg_sequencer.sv
// Arbitrates the segment file read port between prefetch and EU, serialises EU
// segment writes, and forms the 20-bit physical address for the bus cycle unit.
module biu_seg_sequencer #(
  parameter int unsigned STARVE_LIM = 4
) (
  input logic                clk,
  input logic                rst_n,
  biu_seg_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, OUT, WR} state_e;

  state_e      state;
  logic [3:0]  streak;
  logic [15:0] off_q;
  logic        src_q;
  logic        starve_block;
  logic [19:0] pa_sum;

  // A pending prefetch wins once the EU has taken STARVE_LIM grants in a row.
  assign starve_block = bus.pf_req && (streak == 4'(STARVE_LIM));
  // 20-bit sum: the carry out of bit 19 is dropped, so addresses wrap.
  assign pa_sum       = {bus.seg_rd_data, 4'b0000} + {4'b0000, off_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      streak          <= '0;
      off_q           <= '0;
      src_q           <= 1'b0;
      bus.pf_ack      <= 1'b0;
      bus.eu_ack      <= 1'b0;
      bus.sw_ack      <= 1'b0;
      bus.seg_wr_addr <= '0;
      bus.seg_wr_en   <= 1'b0;
      bus.seg_wr_data <= '0;
      bus.seg_rd_addr <= '0;
      bus.seg_rd_en   <= 1'b0;
      bus.pa_valid    <= 1'b0;
      bus.pa          <= '0;
      bus.pa_src      <= 1'b0;
    end else begin
      // NOTE: pulses default low with non-blocking assignments; a later
      // assignment in the same pass overrides it, giving single-cycle strobes.
      bus.pf_ack    <= 1'b0;
      bus.eu_ack    <= 1'b0;
      bus.sw_ack    <= 1'b0;
      bus.seg_wr_en <= 1'b0;
      bus.seg_rd_en <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.sw_req) begin
            bus.seg_wr_addr <= bus.sw_sel;
            bus.seg_wr_data <= bus.sw_data;
            bus.seg_wr_en   <= 1'b1;
            bus.sw_ack      <= 1'b1;
            state           <= WR;
          end else if (bus.eu_req && !starve_block) begin
            bus.seg_rd_addr <= bus.eu_seg;
            bus.seg_rd_en   <= 1'b1;
            off_q           <= bus.eu_off;
            src_q           <= 1'b1;
            bus.eu_ack      <= 1'b1;
            if (streak != 4'hF) streak <= streak + 4'd1;
            state           <= RD;
          end else if (bus.pf_req) begin
            bus.seg_rd_addr <= 2'b00;
            bus.seg_rd_en   <= 1'b1;
            off_q           <= bus.pf_off;
            src_q           <= 1'b0;
            bus.pf_ack      <= 1'b1;
            streak          <= '0;
            state           <= RD;
          end
        end
        // Segment file registers its read data during RD; it is usable in CAP.
        RD:  state <= CAP;
        CAP: begin
          bus.pa       <= pa_sum;
          bus.pa_src   <= src_q;
          bus.pa_valid <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (bus.pa_ready) begin
            bus.pa_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        WR:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/biu_seg_sequencer.md
# biu_seg_sequencer

Sequencer and arbiter for the bus interface unit's segment register file. It shares the file's single read port between the instruction prefetcher and the execution unit (EU), and it serialises EU segment-register writes. For each granted access it forms the 20-bit physical address as (segment << 4) + offset and hands it to the bus cycle unit with a valid/ready handshake.

## Interface
Parameters:
- STARVE_LIM, 4: maximum consecutive EU read grants while a prefetch request is pending, range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- pf_req  in  1  prefetch read request; segment is always CS
- pf_off  in  16  prefetch offset (IP)
- pf_ack  out  1  one-cycle pulse: prefetch request accepted
- eu_req  in  1  EU data read request
- eu_seg  in  2  EU segment select: 00 CS, 01 DS, 10 ES, 11 SS
- eu_off  in  16  EU offset
- eu_ack  out  1  one-cycle pulse: EU request accepted
- sw_req  in  1  EU segment write request
- sw_sel  in  2  segment to write, same encoding as eu_seg
- sw_data  in  16  write data
- sw_ack  out  1  one-cycle pulse: write performed
- seg_wr_addr  out  2  to segment file wr_addr
- seg_wr_en  out  1  to segment file wr_en
- seg_wr_data  out  16  to segment file wr_data
- seg_rd_addr  out  2  to segment file rd_addr
- seg_rd_en  out  1  to segment file rd_en
- seg_rd_data  in  16  from segment file; registered, valid the cycle after seg_rd_en
- pa_valid  out  1  physical address valid
- pa  out  20  physical address
- pa_src  out  1  source of pa: 0 prefetch, 1 EU
- pa_ready  in  1  bus cycle unit accepts pa

## Operation
- FSM states: IDLE, RD, CAP, OUT, WR. All outputs are registered.
- IDLE arbitration, evaluated each cycle in priority order:
  - sw_req: latch sel and data, pulse sw_ack, go to WR.
  - eu_req, when !(pf_req && streak == STARVE_LIM): latch seg and off, set src=1, pulse eu_ack, increment streak (saturating), go to RD.
  - pf_req: latch seg=00 and off, set src=0, pulse pf_ack, clear streak, go to RD.
  - Otherwise, stay in IDLE.
- Streak counter: 4 bits. A prefetch grant clears it. Writes do not affect it. It is not cleared when pf_req is absent.
- WR: seg_wr_en=1 with the latched addr and data for exactly one cycle, then go to IDLE.
- RD: seg_rd_en=1 and seg_rd_addr=latched seg for one cycle, then go to CAP.
- CAP: pa <= ({seg_rd_data,4'b0} + {4'b0,off}) mod 2^20. The carry out of bit 19 is discarded, so the address wraps. Set pa_valid, then go to OUT.
- OUT: hold pa, pa_src and pa_valid stable until pa_ready=1 is sampled, then clear pa_valid and go to IDLE. No new request is accepted before IDLE.
- Requesters hold req and their operands stable until ack. They sample ack at the rising edge.
- Ordering: writes are taken only in IDLE, so an in-flight read always uses the pre-write value. When a write and a read are pending in the same IDLE cycle, the write goes first and the read, granted later, sees the new value.

## Timing
- Reset, asynchronous, while rst_n=0:
  - state=IDLE, streak=0.
  - pf_ack, eu_ack, sw_ack, seg_wr_en, seg_rd_en, pa_valid all 0.
  - seg_wr_addr, seg_rd_addr, pa_src = 0; seg_wr_data, pa = 0.
  - Reset mid-transaction abandons the transaction with no ack or pa re-issue. Requesters must re-request.
- Read latency: request sampled in IDLE at edge 0 → ack high in cycle 0–1 → seg_rd_en high in cycle 1 (RD) → pa captured in cycle 2 (CAP) → pa_valid high from cycle 3.
- Best-case read throughput is one read per 4 cycles, with pa_ready tied high.
- Write: accepted at edge 0 → seg_wr_en high for exactly one cycle, in cycle 1. The next grant can happen from IDLE in cycle 2.
- Ack pulses are exactly one cycle wide, coincident with leaving IDLE.
- pa_ready is ignored outside OUT. pa_valid never drops without pa_ready.

## Test plan
- Reset, then write DS=0x1234 via sw_req, then EU read with eu_seg=01, eu_off=0x0010 → seg_wr_en 1 cycle with addr 01, data 0x1234; pa=0x12350, pa_src=1, pa_valid 3 cycles after the eu request.
- CS=0xFFFF, prefetch pf_off=0x0020 → pa=0x00010 (wrap); pa_src=0.
- sw_req (SS=0x4000) and eu_req (seg 11, off 0) asserted together → write first (sw_ack), then read returns pa=0x40000.
- pf_req held continuously, EU issues back-to-back requests, STARVE_LIM=4 → grant order EU,EU,EU,EU,PF,EU,…; exactly one pf_ack after every 4 eu_acks.
- pa_ready held low 5 cycles in OUT → pa and pa_valid stable for all 5 cycles; no ack to a newly pending request until after the pa_ready cycle.
- rst_n pulsed low during CAP → all outputs 0 immediately (asynchronously); after release, no stale pa_valid; a fresh request completes normally.
